// File: rtl/stash_scan_table_pipe.sv
// stash_scan_table_pipe
// ---------------------------------------------------------------------------
// Decides, for each candidate stash entry, which bucket level of the current
// ORAM path it is written back to, and records it in a path-shaped table of
// (ORAML+1)*ORAMZ slots. The table is streamed out on a ready/valid drain
// port (optionally hiding empty slots) and is then cleared in the background.
//
// Ports
//   Clock, Reset        system clock, asynchronous active-high reset
//   CurrentLeaf         leaf of the path being written back
//   InLeaf/InSAddr      candidate leaf and stash address
//   InValid/InReady     candidate handshake (InReady only in SCAN)
//   OutSAddr            registered copy of the accepted candidate address
//   OutAccepted         candidate was placed in the table
//   OutValid            decision valid (1 cycle after the input handshake)
//   DrainStart          pulse in SCAN: start streaming the table
//   OutSTAddr/OutSTLevel  drained entry and its level (addr / ORAMZ)
//   OutSTValid/OutSTReady drain handshake
//   DrainDone           pulse after the last drained entry
//   Busy                high in INIT, DRAIN and CLEAR
// ---------------------------------------------------------------------------
module stash_scan_table_pipe #(
    parameter int ORAML        = 32,
    parameter int ORAMZ        = 4,
    parameter int StashEAWidth = 7,
    parameter int SkipNull     = 0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [ORAML-1:0]               CurrentLeaf,
    input  logic [ORAML-1:0]               InLeaf,
    input  logic [StashEAWidth-1:0]        InSAddr,
    input  logic                           InValid,
    output logic                           InReady,
    output logic [StashEAWidth-1:0]        OutSAddr,
    output logic                           OutAccepted,
    output logic                           OutValid,
    input  logic                           DrainStart,
    output logic [StashEAWidth-1:0]        OutSTAddr,
    output logic [$clog2(ORAML+1)-1:0]     OutSTLevel,
    output logic                           OutSTValid,
    input  logic                           OutSTReady,
    output logic                           DrainDone,
    output logic                           Busy
);

    localparam int Depth = (ORAML + 1) * ORAMZ;
    localparam int AW    = $clog2(Depth);
    localparam int CW    = $clog2(ORAMZ + 1);
    localparam int LW    = $clog2(ORAML + 1);
    localparam logic [StashEAWidth-1:0] SNULL = {StashEAWidth{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [AW-1:0]           clr_idx_r;
    logic                    clr_last_s;
    logic [CW-1:0]           cnt_r [0:ORAML];
    logic [StashEAWidth-1:0] table_r [0:Depth-1];

    // placement
    logic [ORAML-1:0]        xor_s;
    logic [LW-1:0]           depth_s;
    logic                    found_s;
    logic [LW-1:0]           sel_lvl_s;
    logic [AW-1:0]           place_addr_s;
    logic                    fire_s;

    // table write port
    logic                    wr_en_s;
    logic [AW-1:0]           wr_addr_s;
    logic [StashEAWidth-1:0] wr_data_s;

    // drain read side
    logic [AW-1:0]           rd_ptr_r;
    logic [LW-1:0]           rd_lvl_r;
    logic [CW-1:0]           rd_slot_r;
    logic                    issue_done_r;
    logic                    rd_valid_r;
    logic [StashEAWidth-1:0] rd_data_r;
    logic [LW-1:0]           rd_dlvl_r;
    logic                    issue_s;
    logic                    skip_s;
    logic                    push_s;
    logic                    pop_s;
    logic [1:0]              occ_s;
    logic                    drain_fin_s;

    // drain output register plus one skid slot
    logic                    ov_r;
    logic [StashEAWidth-1:0] out_addr_r;
    logic [LW-1:0]           out_lvl_r;
    logic                    sv_r;
    logic [StashEAWidth-1:0] sk_addr_r;
    logic [LW-1:0]           sk_lvl_r;
    logic                    done_r;

    // decision registers
    logic                    dec_valid_r;
    logic                    dec_acc_r;
    logic [StashEAWidth-1:0] dec_saddr_r;

    assign InReady     = (state_r == ST_SCAN);
    assign Busy        = (state_r != ST_SCAN);
    assign fire_s      = InValid & InReady;
    assign clr_last_s  = (clr_idx_r == AW'(Depth - 1));
    assign OutValid    = dec_valid_r;
    assign OutAccepted = dec_acc_r;
    assign OutSAddr    = dec_saddr_r;
    assign OutSTValid  = ov_r;
    assign OutSTAddr   = out_addr_r;
    assign OutSTLevel  = out_lvl_r;
    assign DrainDone   = done_r;

    // Common path depth and deepest non-full level that the candidate may use
    always_comb begin
        xor_s        = InLeaf ^ CurrentLeaf;
        depth_s      = LW'(ORAML);
        found_s      = 1'b0;
        sel_lvl_s    = '0;
        place_addr_s = '0;
        // Walk MSB to LSB so the lowest differing bit wins: d = trailing equal bits.
        for (int i = ORAML - 1; i >= 0; i--) begin
            depth_s = xor_s[i] ? LW'(i) : depth_s;
        end
        // Later (deeper) eligible levels override earlier ones.
        for (int k = 0; k <= ORAML; k++) begin
            if ((LW'(k) <= depth_s) && (cnt_r[k] < CW'(ORAMZ))) begin
                found_s      = 1'b1;
                sel_lvl_s    = LW'(k);
                place_addr_s = AW'(k * ORAMZ) + AW'(cnt_r[k]);
            end else begin
                found_s      = found_s;
            end
        end
    end

    // Table write port: SNULL sweep in INIT/CLEAR, placements in SCAN
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = SNULL;
        case (state_r)
            ST_INIT, ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_idx_r;
                wr_data_s = SNULL;
            end
            ST_SCAN: begin
                wr_en_s   = fire_s & found_s;
                wr_addr_s = place_addr_s;
                wr_data_s = InSAddr;
            end
            default: begin
                wr_en_s   = 1'b0;
            end
        endcase
    end

    // Drain flow control: at most two entries held or in flight, counting the pop
    always_comb begin
        pop_s       = ov_r & OutSTReady;
        skip_s      = (SkipNull != 0) ? (rd_data_r == SNULL) : 1'b0;
        push_s      = rd_valid_r & ~skip_s;
        occ_s       = 2'(ov_r) + 2'(sv_r) + 2'(rd_valid_r);
        issue_s     = (state_r == ST_DRAIN) && !issue_done_r &&
                      (occ_s < (2'd2 + 2'(pop_s)));
        drain_fin_s = (state_r == ST_DRAIN) && issue_done_r && !rd_valid_r &&
                      !sv_r && (!ov_r || pop_s);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (clr_last_s) state_s = ST_SCAN;
                else            state_s = ST_INIT;
            end
            ST_SCAN: begin
                if (DrainStart) state_s = ST_DRAIN;
                else            state_s = ST_SCAN;
            end
            ST_DRAIN: begin
                if (drain_fin_s) state_s = ST_CLEAR;
                else             state_s = ST_DRAIN;
            end
            ST_CLEAR: begin
                if (clr_last_s) state_s = ST_SCAN;
                else            state_s = ST_CLEAR;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_r <= ST_INIT;
        else       state_r <= state_s;
    end

    // Clear sweep index, returns to 0 when the sweep ends
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clr_idx_r <= '0;
        end else if ((state_r == ST_INIT) || (state_r == ST_CLEAR)) begin
            clr_idx_r <= clr_last_s ? '0 : (clr_idx_r + AW'(1));
        end else begin
            clr_idx_r <= '0;
        end
    end

    // Per-level occupancy; zeroed as the drain hands over to CLEAR
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k <= ORAML; k++) cnt_r[k] <= '0;
        end else if (drain_fin_s) begin
            for (int k = 0; k <= ORAML; k++) cnt_r[k] <= '0;
        end else if (fire_s && found_s) begin
            for (int k = 0; k <= ORAML; k++) begin
                if (sel_lvl_s == LW'(k)) cnt_r[k] <= cnt_r[k] + CW'(1);
            end
        end
    end

    // Decision outputs, one cycle after the input handshake
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dec_valid_r <= 1'b0;
            dec_acc_r   <= 1'b0;
            dec_saddr_r <= '0;
        end else begin
            dec_valid_r <= fire_s;
            dec_acc_r   <= fire_s & found_s;
            if (fire_s) dec_saddr_r <= InSAddr;
        end
    end

    // Table storage: one write port, one synchronous read port for the drain
    always_ff @(posedge Clock) begin
        if (wr_en_s) table_r[wr_addr_s] <= wr_data_s;
        if (issue_s) rd_data_r <= table_r[rd_ptr_r];
    end

    // Drain read pointer with level/slot tracking (avoids a divider)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr_r     <= '0;
            rd_lvl_r     <= '0;
            rd_slot_r    <= '0;
            issue_done_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_dlvl_r    <= '0;
        end else begin
            rd_valid_r <= issue_s;
            if (state_r != ST_DRAIN) begin
                rd_ptr_r     <= '0;
                rd_lvl_r     <= '0;
                rd_slot_r    <= '0;
                issue_done_r <= 1'b0;
            end else if (issue_s) begin
                rd_dlvl_r <= rd_lvl_r;
                if (rd_ptr_r == AW'(Depth - 1)) issue_done_r <= 1'b1;
                else                             rd_ptr_r     <= rd_ptr_r + AW'(1);
                if (rd_slot_r == CW'(ORAMZ - 1)) begin
                    rd_slot_r <= '0;
                    rd_lvl_r  <= rd_lvl_r + LW'(1);
                end else begin
                    rd_slot_r <= rd_slot_r + CW'(1);
                end
            end
        end
    end

    // Output register + skid: data held stable until accepted
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ov_r       <= 1'b0;
            out_addr_r <= '0;
            out_lvl_r  <= '0;
            sv_r       <= 1'b0;
            sk_addr_r  <= '0;
            sk_lvl_r   <= '0;
        end else if (state_r != ST_DRAIN) begin
            ov_r <= 1'b0;
            sv_r <= 1'b0;
        end else if (pop_s || !ov_r) begin
            if (sv_r) begin
                ov_r       <= 1'b1;
                out_addr_r <= sk_addr_r;
                out_lvl_r  <= sk_lvl_r;
                sv_r       <= push_s;
                sk_addr_r  <= rd_data_r;
                sk_lvl_r   <= rd_dlvl_r;
            end else begin
                ov_r <= push_s;
                if (push_s) begin
                    out_addr_r <= rd_data_r;
                    out_lvl_r  <= rd_dlvl_r;
                end
            end
        end else if (push_s) begin
            sv_r      <= 1'b1;
            sk_addr_r <= rd_data_r;
            sk_lvl_r  <= rd_dlvl_r;
        end
    end

    // Drain completion pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) done_r <= 1'b0;
        else       done_r <= drain_fin_s;
    end

endmodule
